pe_dataflow_scheduler: RTL and testbench

- Sequences one PE group per job by driving the edge-dataflow address controller's strobes: EN_W, EN_I, EN_O_In, EN_O_Out and the controller's synchronous clear.
- Job order: one weight load, then for each of I_BlockCount input blocks: input load, output accumulate-in, output drain.
- Sits between the buffer/DMA handshakes (w_valid, i_valid, o_ready) and the PE address controller.
- Exposes a start/busy/done handshake to the layer sequencer.

---
 rtl/pe_dataflow_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_pe_dataflow_scheduler.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pe_dataflow_scheduler.sv
// rtl/pe_dataflow_scheduler.sv - per-job strobe sequencer for the PE edge-dataflow address controller (optional weight reuse: PE_SCHED_WEIGHT_REUSE_EN)
module pe_dataflow_scheduler #(
    parameter int W_PEGroupSize = 4,
    parameter int O_PEGroupSize = 4,
    parameter int I_PEGroupSize = W_PEGroupSize + O_PEGroupSize - 1,
    parameter int I_BlockCount  = 4,
    parameter int CntWidth      = 4
) (
    input  logic                clk,
    input  logic                aclr,
    input  logic                sclr,
    input  logic                start,
`ifdef PE_SCHED_WEIGHT_REUSE_EN
    input  logic                reuse_w,
`endif
    input  logic                w_valid,
    input  logic                i_valid,
    input  logic                o_ready,
    output logic                busy,
    output logic                done,
    output logic                EN_W,
    output logic                EN_I,
    output logic                EN_O_In,
    output logic                EN_O_Out,
    output logic                PE_sclr,
    output logic [CntWidth-1:0] block_idx,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_LOAD_W = 3'd2,
        S_LOAD_I = 3'd3,
        S_ACCUM  = 3'd4,
        S_DRAIN  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [CntWidth-1:0] W_LAST   = CntWidth'(W_PEGroupSize - 1);
    localparam logic [CntWidth-1:0] I_LAST   = CntWidth'(I_PEGroupSize - 1);
    localparam logic [CntWidth-1:0] O_LAST   = CntWidth'(O_PEGroupSize - 1);
    localparam logic [CntWidth-1:0] BLK_LAST = CntWidth'(I_BlockCount - 1);

    state_t              cur_state;
    state_t              nxt_state;
    logic [CntWidth-1:0] cnt;
    logic                cnt_inc;
    logic                cnt_clr;
    logic                blk_inc;
    logic                blk_clr;
    logic                w_done;
    logic                skip_w;

    assign state   = cur_state;
    assign PE_sclr = sclr | (cur_state == S_CLEAR);

`ifdef PE_SCHED_WEIGHT_REUSE_EN
    logic w_loaded;

    // Remember that the weight tile is resident, and decide at job start whether to skip reloading it
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            w_loaded <= 1'b0;
            skip_w   <= 1'b0;
        end else if (sclr) begin
            w_loaded <= 1'b0;
            skip_w   <= 1'b0;
        end else begin
            if (w_done)
                w_loaded <= 1'b1;
            if (cur_state == S_IDLE && start)
                skip_w <= reuse_w & w_loaded;
        end
    end
`else
    assign skip_w = 1'b0;
`endif

    // State register; sclr behaves like aclr but only on a clock edge
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr)
            cur_state <= S_IDLE;
        else if (sclr)
            cur_state <= S_IDLE;
        else
            cur_state <= nxt_state;
    end

    // Element counter and block index, both driven by the strobes decoded below
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            cnt       <= '0;
            block_idx <= '0;
        end else if (sclr) begin
            cnt       <= '0;
            block_idx <= '0;
        end else begin
            if (cnt_clr)
                cnt <= '0;
            else if (cnt_inc)
                cnt <= cnt + 1'b1;
            if (blk_clr)
                block_idx <= '0;
            else if (blk_inc)
                block_idx <= block_idx + 1'b1;
        end
    end

    // Next-state decode and handshake-gated pointer strobes; only the current phase's handshake matters
    always_comb begin
        nxt_state = cur_state;
        busy      = 1'b1;
        done      = 1'b0;
        EN_W      = 1'b0;
        EN_I      = 1'b0;
        EN_O_In   = 1'b0;
        EN_O_Out  = 1'b0;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        blk_inc   = 1'b0;
        blk_clr   = 1'b0;
        w_done    = 1'b0;
        case (cur_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start)
                    nxt_state = S_CLEAR;
            end
            S_CLEAR: begin
                cnt_clr   = 1'b1;
                blk_clr   = 1'b1;
                nxt_state = skip_w ? S_LOAD_I : S_LOAD_W;
            end
            S_LOAD_W: begin
                EN_W = w_valid;
                if (w_valid) begin
                    if (cnt == W_LAST) begin
                        cnt_clr   = 1'b1;
                        w_done    = 1'b1;
                        nxt_state = S_LOAD_I;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_LOAD_I: begin
                EN_I = i_valid;
                if (i_valid) begin
                    if (cnt == I_LAST) begin
                        cnt_clr   = 1'b1;
                        nxt_state = S_ACCUM;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_ACCUM: begin
                EN_O_In = 1'b1;
                if (cnt == O_LAST) begin
                    cnt_clr   = 1'b1;
                    nxt_state = S_DRAIN;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_DRAIN: begin
                EN_O_Out = o_ready;
                if (o_ready) begin
                    if (cnt == O_LAST) begin
                        cnt_clr = 1'b1;
                        if (block_idx == BLK_LAST) begin
                            nxt_state = S_DONE;
                        end else begin
                            blk_inc   = 1'b1;
                            nxt_state = S_LOAD_I;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_DONE: begin
                done      = 1'b1;
                blk_clr   = 1'b1;
                nxt_state = S_IDLE;
            end
            default: begin
                busy      = 1'b0;
                nxt_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pe_dataflow_scheduler.sv
// tb/tb_pe_dataflow_scheduler.sv - scoreboard bench for pe_dataflow_scheduler
module tb_pe_dataflow_scheduler;

    logic       clk = 1'b0;
    logic       aclr, sclr, start, reuse_w, w_valid, i_valid, o_ready;
    logic       busy, done, EN_W, EN_I, EN_O_In, EN_O_Out, PE_sclr;
    logic [3:0] block_idx;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int mode;      // 0 plain, 1 i_valid toggle, 2 drain stall, 3 start while busy, 4 sclr before start
        bit reuse;
        int exp_done;
        int exp_w;
        int exp_i;
        int exp_oi;
        int exp_oo;
        int exp_sclr;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    pe_dataflow_scheduler dut (
        .clk(clk), .aclr(aclr), .sclr(sclr), .start(start),
`ifdef PE_SCHED_WEIGHT_REUSE_EN
        .reuse_w(reuse_w),
`endif
        .w_valid(w_valid), .i_valid(i_valid), .o_ready(o_ready),
        .busy(busy), .done(done), .EN_W(EN_W), .EN_I(EN_I),
        .EN_O_In(EN_O_In), .EN_O_Out(EN_O_Out), .PE_sclr(PE_sclr),
        .block_idx(block_idx), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_state"}, state, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_en"}, {EN_W, EN_I, EN_O_In, EN_O_Out}, 0);
        check({name, "_blk"}, block_idx, 0);
    endtask

    // Wait (at negedges) until the DUT reaches a given state and block; bounded
    task automatic wait_state(input int s, input int blk);
        int n = 0;
        while (!(state == 3'(s) && block_idx == 4'(blk)) && n < 200) begin
            @(posedge clk); #1; start = 1'b0;
            @(negedge clk);
            n++;
        end
        check("wait_state_reached", (state == 3'(s) && block_idx == 4'(blk)), 1);
    endtask

    task automatic run_job(input vec_t v);
        int c = 0, nw = 0, ni = 0, noi = 0, noo = 0, ns = 0, phase = 0, stall = 0;
        bit seen = 0;
        vec_t e;
        if (v.mode == 4) begin
            @(posedge clk); #1 sclr = 1'b1;
            @(posedge clk); #1 sclr = 1'b0;
        end
        reuse_w = v.reuse;
        w_valid = 1'b1;
        i_valid = (v.mode != 1);
        o_ready = 1'b1;
        start   = 1'b1;
        sb.push_back(v);
        while (!seen && c < 300) begin
            @(posedge clk); c++; #1;
            start = (v.mode == 3 && c == 20);
            if (v.mode == 1) begin
                if (state == 3'd3) begin
                    i_valid = phase[0];
                    phase ^= 1;
                end else begin
                    i_valid = 1'b0;
                    phase = 0;
                end
            end
            if (v.mode == 2) begin
                if (state == 3'd5 && block_idx == 4'd2 && stall < 10) begin
                    o_ready = 1'b0;
                    stall++;
                end else begin
                    o_ready = 1'b1;
                end
            end
            @(negedge clk);
            check("en_legal",
                  ($countones({EN_W, EN_I, EN_O_In, EN_O_Out}) <= 1) &&
                  (!EN_W || w_valid) && (!EN_I || i_valid) && (!EN_O_Out || o_ready), 1);
            if (c == 1)
                check("clear_cycle1", {state, PE_sclr}, {3'd1, 1'b1});
            if (v.mode == 2 && !o_ready)
                check("drain_stall_hold", {state, block_idx, EN_O_Out}, {3'd5, 4'd2, 1'b0});
            nw  += EN_W;
            ni  += EN_I;
            noi += EN_O_In;
            noo += EN_O_Out;
            ns  += PE_sclr;
            if (done) begin
                seen = 1;
                e = sb.pop_front();
                check("done_cycle", c, e.exp_done);
                check("n_en_w", nw, e.exp_w);
                check("n_en_i", ni, e.exp_i);
                check("n_en_o_in", noi, e.exp_oi);
                check("n_en_o_out", noo, e.exp_oo);
                check("n_pe_sclr", ns, e.exp_sclr);
            end
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            void'(sb.pop_front());
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("post_done_idle", {busy, done, state}, 0);
    endtask

    initial begin
        aclr = 1'b1; sclr = 1'b0; start = 1'b0; reuse_w = 1'b0;
        w_valid = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
        #12;
        check_idle_outputs("reset");
        check("reset_pe_sclr", PE_sclr, 0);
        @(posedge clk); #1 aclr = 1'b0;

        vecs.push_back('{0, 0, 66, 4, 28, 16, 16, 1});
        vecs.push_back('{1, 0, 94, 4, 28, 16, 16, 1});
        vecs.push_back('{2, 0, 76, 4, 28, 16, 16, 1});
        vecs.push_back('{3, 0, 66, 4, 28, 16, 16, 1});
`ifdef PE_SCHED_WEIGHT_REUSE_EN
        vecs.push_back('{0, 1, 62, 0, 28, 16, 16, 1});
        vecs.push_back('{4, 1, 66, 4, 28, 16, 16, 1});
`else
        vecs.push_back('{0, 0, 66, 4, 28, 16, 16, 1});
`endif
        foreach (vecs[k])
            run_job(vecs[k]);

        // aclr mid-ACCUM of block 1: immediate return to IDLE
        w_valid = 1'b1; i_valid = 1'b1; o_ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        wait_state(4, 1);
        #2 aclr = 1'b1;
        #1;
        check_idle_outputs("aclr_mid_accum");
        @(posedge clk); #1 aclr = 1'b0;

        // sclr mid-LOAD_I: PE_sclr same cycle, IDLE after the edge
        start = 1'b1;
        wait_state(3, 0);
        @(posedge clk); #1 sclr = 1'b1;
        @(negedge clk);
        check("sclr_pe_sclr", {PE_sclr, state}, {1'b1, 3'd3});
        @(posedge clk); #1 sclr = 1'b0;
        check_idle_outputs("sclr_mid_load_i");

        run_job('{0, 0, 66, 4, 28, 16, 16, 1});

        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
